// File: rtl/game_pkg.sv
// Shared game definitions: command codes, tile ids and the command legality
// check used by the intake queue.
package game_pkg;

  // Width of the argument to cmd_legal; callers zero-extend their command into it.
  localparam int unsigned CMD_CHK_W = 64;

  localparam logic [15:0] CMD_RIGHT    = 16'h0001;
  localparam logic [15:0] CMD_LEFT     = 16'h0002;
  localparam logic [15:0] CMD_UP       = 16'h0003;
  localparam logic [15:0] CMD_DOWN     = 16'h0004;
  localparam logic [15:0] CMD_ATTACK   = 16'h0005;
  localparam logic [15:0] CMD_RUN      = 16'h0006;
  localparam logic [15:0] CMD_NOSHROUD = 16'h0010;

  typedef enum logic [2:0] {
    TILE_UNKNOWN = 3'd0,
    TILE_FLOOR   = 3'd1,
    TILE_WALL    = 3'd2,
    TILE_DOOR    = 3'd3,
    TILE_ITEM    = 3'd4,
    TILE_EXIT    = 3'd5,
    TILE_ENEMY   = 3'd6
  } tile_e;

  // Movement only while exploring, attack/run only in combat, the shroud
  // toggle only with hacks enabled; everything else is rejected.
  function automatic logic cmd_legal(input logic [CMD_CHK_W-1:0] cmd,
                                     input logic on_enemy,
                                     input logic hacks_en);
    logic legal;
    legal = 1'b0;
    if ((cmd >= 64'(CMD_RIGHT)) && (cmd <= 64'(CMD_DOWN))) begin
      legal = !on_enemy;
    end else if ((cmd == 64'(CMD_ATTACK)) || (cmd == 64'(CMD_RUN))) begin
      legal = on_enemy;
    end else if (cmd == 64'(CMD_NOSHROUD)) begin
      legal = hacks_en;
    end else begin
      legal = 1'b0;
    end
    return legal;
  endfunction

endpackage

// File: rtl/cmdq_fifo.sv
// Command storage for cmd_queue: circular buffer with read/write pointers,
// occupancy level and full/empty flags. rd_cmd reads 0 when empty.
module cmdq_fifo #(
  parameter  int DEPTH = 8,
  parameter  int CMD_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] wr_cmd,
  input  logic             pop,
  output logic [CMD_W-1:0] rd_cmd,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == {LVL_W{1'b0}});
  assign level  = level_q;
  assign rd_cmd = empty ? {CMD_W{1'b0}} : mem_q[rd_ptr_q];

  // Next pointers, level and storage; pointers wrap naturally at DEPTH.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wr_cmd;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cmd_queue.sv
// Command intake queue ahead of the game engine. Buffers player commands,
// drops code 0 on entry and, when CMDQ_VALIDATE_EN is defined, discards head
// commands that are illegal for the engine's current mode. Without that macro
// every stored command is delivered and on_enemy/hacks_en are ignored.
module cmd_queue
  import game_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CMD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CMD_W-1:0]         in_cmd,
  output logic                     in_ready,
  input  logic                     on_enemy,
  input  logic                     hacks_en,
  output logic                     out_valid,
  output logic [CMD_W-1:0]         out_cmd,
  input  logic                     out_ready,
  output logic                     drop_pulse,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] head_cmd_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic             full_s;
  logic             empty_s;
  logic             head_legal_s;
  logic             push_acc_s;
  logic             push_zero_s;
  logic             fifo_push_s;
  logic             discard_s;
  logic             pop_s;
  logic [8:0]       drop_sum_s;
  logic             drop_pulse_q, drop_pulse_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             unused_mode_s;

  cmdq_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push_s),
    .wr_cmd (in_cmd),
    .pop    (pop_s),
    .rd_cmd (head_cmd_s),
    .level  (fifo_level_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Head legality against the current engine mode (or always legal).
  always_comb begin
`ifdef CMDQ_VALIDATE_EN
    head_legal_s  = cmd_legal(CMD_CHK_W'(head_cmd_s), on_enemy, hacks_en);
    unused_mode_s = 1'b0;
`else
    head_legal_s  = 1'b1;
    unused_mode_s = on_enemy ^ hacks_en;
`endif
  end

  // Handshake, zero-code drop, and head pop/discard decisions.
  always_comb begin
    in_ready    = !full_s;
    push_acc_s  = in_valid && !full_s;
    push_zero_s = push_acc_s && (in_cmd == {CMD_W{1'b0}});
    fifo_push_s = push_acc_s && !push_zero_s;
    out_valid   = !empty_s && head_legal_s;
    discard_s   = !empty_s && !head_legal_s;
    pop_s       = (out_valid && out_ready) || discard_s;
  end

  // Drop counter update: up to two drops per cycle, saturating at 255.
  always_comb begin
    drop_sum_s   = {1'b0, drop_count_q} + {8'd0, push_zero_s} + {8'd0, discard_s};
    drop_pulse_d = push_zero_s || discard_s;
    if (drop_sum_s[8]) begin
      drop_count_d = 8'hFF;
    end else begin
      drop_count_d = drop_sum_s[7:0];
    end
  end

  // Drop pulse and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_cmd    = head_cmd_s;
  assign level      = fifo_level_s;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed self-checking bench for cmd_queue. Mode-filtering sequences are
// selected by CMDQ_VALIDATE_EN to match the build under test.
module tb_cmd_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_cmd;
  logic        in_ready;
  logic        on_enemy;
  logic        hacks_en;
  logic        out_valid;
  logic [15:0] out_cmd;
  logic        out_ready;
  logic        drop_pulse;
  logic [7:0]  drop_count;
  logic [3:0]  level;

  int n_cmp;
  int n_bad;
  int exp_dc;

  typedef struct {
    logic        iv;
    logic [15:0] cmd;
    logic        oe;
    logic        he;
    logic        ordy;
    logic        ov;
    logic [15:0] oc;
    logic        ir;
    logic [3:0]  lvl;
    logic        dp;
    logic [7:0]  dc;
  } vec_t;

  vec_t tbl [13];
  logic [15:0] fill_codes [8];

  cmd_queue #(.DEPTH(8), .CMD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_cmd     (in_cmd),
    .in_ready   (in_ready),
    .on_enemy   (on_enemy),
    .hacks_en   (hacks_en),
    .out_valid  (out_valid),
    .out_cmd    (out_cmd),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Drive inputs, check outputs before the next edge, then advance one cycle.
  task automatic cyc(input string nm,
                     input logic iv, input logic [15:0] cmd,
                     input logic oe, input logic he, input logic ordy,
                     input logic ev, input logic [15:0] ec, input logic eir,
                     input logic [3:0] el, input logic edp, input int edc);
    logic [7:0] edc8;
    edc8      = edc[7:0];
    in_valid  = iv;
    in_cmd    = cmd;
    on_enemy  = oe;
    hacks_en  = he;
    out_ready = ordy;
    #1;
    n_cmp++;
    if ({out_valid, out_cmd, in_ready, level, drop_pulse, drop_count} !==
        {ev, ec, eir, el, edp, edc8}) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b cmd=%h in_ready=%0b level=%0d pulse=%0b count=%0d, want valid=%0b cmd=%h in_ready=%0b level=%0d pulse=%0b count=%0d",
               nm, out_valid, out_cmd, in_ready, level, drop_pulse, drop_count,
               ev, ec, eir, el, edp, edc8);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_cmd = 16'h0; on_enemy = 1'b0;
    hacks_en = 1'b0; out_ready = 1'b0;

    tbl[0]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 4'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 4'd1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 4'd1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 4'd1, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 4'd1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, 8'd2};

    fill_codes[0] = 16'd1; fill_codes[1] = 16'd2; fill_codes[2] = 16'd3; fill_codes[3] = 16'd4;
    fill_codes[4] = 16'd1; fill_codes[5] = 16'd2; fill_codes[6] = 16'd3; fill_codes[7] = 16'd4;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, basic order, zero drops, hold and pop with zero drop.
    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].iv, tbl[i].cmd, tbl[i].oe, tbl[i].he, tbl[i].ordy,
          tbl[i].ov, tbl[i].oc, tbl[i].ir, tbl[i].lvl, tbl[i].dp, int'(tbl[i].dc));
    end
    exp_dc = 2;

    // Fill to full with the engine stalled.
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("fill%0d", i), 1'b1, fill_codes[i], 1'b0, 1'b0, 1'b0,
          (i > 0), (i > 0) ? 16'd1 : 16'd0, 1'b1, 4'(i), 1'b0, exp_dc);
    end
    cyc("full_9th_push", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 4'd8, 1'b0, exp_dc);
    cyc("full_pop_no_pass", 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 4'd8, 1'b0, exp_dc);
    for (int k = 0; k < 7; k++) begin
      cyc($sformatf("drain%0d", k), 1'b0, 16'd0, 1'b0, 1'b0, 1'b1,
          1'b1, fill_codes[k+1], 1'b1, 4'(7 - k), 1'b0, exp_dc);
    end
    cyc("drained", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);

`ifdef CMDQ_VALIDATE_EN
    // Combat discard: move is dropped, attack delivered.
    cyc("cmb_push3", 1'b1, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("cmb_head3", 1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("cmb_head5", 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 4'd1, 1'b1, exp_dc + 1);
    exp_dc = exp_dc + 1;
    cyc("cmb_empty", 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    // Shroud toggle without hacks is discarded.
    cyc("nh_push", 1'b1, 16'h10, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("nh_head", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h10, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("nh_drop", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, exp_dc + 1);
    exp_dc = exp_dc + 1;
    // Shroud toggle with hacks delivered in combat and exploring.
    cyc("hc_push", 1'b1, 16'h10, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("hc_head", 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h10, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("hx_push", 1'b1, 16'h10, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("hx_head", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h10, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("hx_empty", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    // Mode flip while the engine stalls turns a legal head into a discard.
    cyc("mf_push", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("mf_legal", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("mf_flip", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("mf_drop", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, exp_dc + 1);
    exp_dc = exp_dc + 1;
    // Unknown code at head plus a zero push in the same cycle: two drops.
    cyc("cd_push7", 1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("cd_both", 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("cd_after", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, exp_dc + 2);
    exp_dc = exp_dc + 2;
`else
    // Without validation every stored code is delivered in any mode.
    cyc("nv_push1", 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
    cyc("nv_push7", 1'b1, 16'd7, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("nv_push10", 1'b1, 16'h10, 1'b1, 1'b0, 1'b1, 1'b1, 16'd7, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("nv_head10", 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h10, 1'b1, 4'd1, 1'b0, exp_dc);
    cyc("nv_empty", 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, exp_dc);
`endif

    // Drop counter saturation with a stream of zero codes.
    for (int i = 0; i < 300; i++) begin
      cyc($sformatf("sat%0d", i), 1'b1, 16'd0, 1'b0, 1'b0, 1'b1,
          1'b0, 16'd0, 1'b1, 4'd0, (i > 0), sat(exp_dc + i));
    end
    cyc("sat_last_pulse", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b1, 255);
    cyc("sat_hold", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 255);

    // Reset mid-stream with four entries queued and a push in the reset cycle.
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("pre_rst%0d", i), 1'b1, fill_codes[i], 1'b0, 1'b0, 1'b0,
          (i > 0), (i > 0) ? 16'd1 : 16'd0, 1'b1, 4'(i), 1'b0, 255);
    end
    rst = 1'b1;
    cyc("rst_cycle", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 4'd4, 1'b0, 255);
    rst = 1'b0;
    cyc("post_rst", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 0);
    cyc("post_rst_push", 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 0);
    cyc("post_rst_head", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 4'd1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
